// File: rtl/bcd_event_counter.sv
// Four-digit BCD up/down event counter with load, wrap/load-error pulses and
// registered active-low seven-segment outputs. Counts rising edges of tick_in.
module bcd_event_counter #(
  parameter int MAX_VALUE = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_in,
  input  logic        en,
  input  logic        up,
  input  logic        load,
  input  logic [15:0] load_val,
  output logic [15:0] count,
  output logic        wrap,
  output logic        load_err,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3
);

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  localparam logic [15:0] MAX_BCD = to_bcd(MAX_VALUE);

  function automatic logic [15:0] bcd_inc(input logic [15:0] c);
    logic [15:0] r;
    logic        carry;
    r     = c;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    bcd_inc = r;
  endfunction

  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [15:0] r;
    logic        borrow;
    r      = c;
    borrow = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (borrow) begin
        if (r[i*4 +: 4] == 4'd0) begin
          r[i*4 +: 4] = 4'd9;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    bcd_dec = r;
  endfunction

  // With every nibble <= 9, unsigned compare of the BCD word orders like decimal.
  function automatic logic load_ok(input logic [15:0] v);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (v[i*4 +: 4] > 4'd9) ok = 1'b0;
    end
    load_ok = ok && (v <= MAX_BCD);
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  logic        tick_prev;
  logic        rise;
  logic [15:0] count_d;
  logic        wrap_d;
  logic        load_err_d;

  assign rise = tick_in & ~tick_prev;

  always_comb begin
    count_d    = count;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      if (load_ok(load_val)) count_d = load_val;
      else                   load_err_d = 1'b1;
    end else if (rise && en) begin
      if (up) begin
        if (count == MAX_BCD) begin
          count_d = 16'h0000;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_inc(count);
        end
      end else begin
        if (count == 16'h0000) begin
          count_d = MAX_BCD;
          wrap_d  = 1'b1;
        end else begin
          count_d = bcd_dec(count);
        end
      end
    end
  end

  // Stage 0: edge history (free-running through reset) and count state
  always_ff @(posedge clk) begin
    tick_prev <= tick_in;
    if (rst) begin
      count    <= 16'h0000;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count    <= count_d;
      wrap     <= wrap_d;
      load_err <= load_err_d;
    end
  end

  // Stage 1: segment decode registered one cycle behind count
  always_ff @(posedge clk) begin
    if (rst) begin
      hex0 <= 7'b1000000;
      hex1 <= 7'b1000000;
      hex2 <= 7'b1000000;
      hex3 <= 7'b1000000;
    end else begin
      hex0 <= seg_decode(count[3:0]);
      hex1 <= seg_decode(count[7:4]);
      hex2 <= seg_decode(count[11:8]);
      hex3 <= seg_decode(count[15:12]);
    end
  end

endmodule

// File: tb/tb_bcd_event_counter.sv
// Scoreboard bench: two counters (MAX 9999 and MAX 59) share stimulus and are
// checked every cycle against a decimal reference model.
module tb_bcd_event_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_in = 1'b0;
  logic        en = 1'b0;
  logic        up = 1'b1;
  logic        load = 1'b0;
  logic [15:0] load_val = 16'h0000;

  logic [15:0] a_count, b_count;
  logic        a_wrap, b_wrap, a_err, b_err;
  logic [6:0]  a_hex0, a_hex1, a_hex2, a_hex3;
  logic [6:0]  b_hex0, b_hex1, b_hex2, b_hex3;

  always #5 clk = ~clk;

  bcd_event_counter #(.MAX_VALUE(9999)) dut_a (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(a_count), .wrap(a_wrap), .load_err(a_err),
    .hex0(a_hex0), .hex1(a_hex1), .hex2(a_hex2), .hex3(a_hex3));

  bcd_event_counter #(.MAX_VALUE(59)) dut_b (
    .clk(clk), .rst(rst), .tick_in(tick_in), .en(en), .up(up), .load(load),
    .load_val(load_val), .count(b_count), .wrap(b_wrap), .load_err(b_err),
    .hex0(b_hex0), .hex1(b_hex1), .hex2(b_hex2), .hex3(b_hex3));

  typedef struct {
    logic [15:0] cnt;
    logic        wrap;
    logic        err;
    logic [27:0] hex;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   m_val[2] = '{0, 0};
  int   m_max[2] = '{9999, 59};
  logic m_prev   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: seg7 = 7'b1000000;  1: seg7 = 7'b1111001;  2: seg7 = 7'b0100100;
      3: seg7 = 7'b0110000;  4: seg7 = 7'b0011001;  5: seg7 = 7'b0010010;
      6: seg7 = 7'b0000010;  7: seg7 = 7'b1111000;  8: seg7 = 7'b0000000;
      9: seg7 = 7'b0010000;  default: seg7 = 7'b1111111;
    endcase
  endfunction

  function automatic logic [15:0] dec2bcd(input int v);
    dec2bcd = {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic logic [27:0] hex_of(input int v);
    hex_of = {seg7(v / 1000 % 10), seg7(v / 100 % 10), seg7(v / 10 % 10), seg7(v % 10)};
  endfunction

  // Computes next state for both counters from the inputs now on the pins.
  task automatic model_step();
    logic rise_m;
    rise_m = tick_in & ~m_prev;
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      e.wrap = 1'b0;
      e.err  = 1'b0;
      if (rst) begin
        m_val[k] = 0;
        e.hex    = hex_of(0);
      end else begin
        e.hex = hex_of(m_val[k]);
        if (load) begin
          logic [15:0] lv;
          bit          nib_ok;
          int          dec;
          lv     = load_val;
          nib_ok = 1'b1;
          dec    = 0;
          for (int i = 3; i >= 0; i--) begin
            if (lv[i*4 +: 4] > 4'd9) nib_ok = 1'b0;
            dec = dec * 10 + int'(lv[i*4 +: 4]);
          end
          if (nib_ok && dec <= m_max[k]) m_val[k] = dec;
          else e.err = 1'b1;
        end else if (rise_m && en) begin
          if (up) begin
            if (m_val[k] == m_max[k]) begin m_val[k] = 0; e.wrap = 1'b1; end
            else m_val[k] = m_val[k] + 1;
          end else begin
            if (m_val[k] == 0) begin m_val[k] = m_max[k]; e.wrap = 1'b1; end
            else m_val[k] = m_val[k] - 1;
          end
        end
      end
      e.cnt = dec2bcd(m_val[k]);
      exp_q.push_back(e);
    end
    m_prev = tick_in;
  endtask

  task automatic compare_all();
    exp_t e;
    if (exp_q.size() < 2) begin
      check("queue_depth", 32'(exp_q.size()), 32'd2);
      return;
    end
    e = exp_q.pop_front();
    check("a_count", {16'h0, a_count}, {16'h0, e.cnt});
    check("a_wrap", {31'h0, a_wrap}, {31'h0, e.wrap});
    check("a_load_err", {31'h0, a_err}, {31'h0, e.err});
    check("a_hex", {4'h0, a_hex3, a_hex2, a_hex1, a_hex0}, {4'h0, e.hex});
    e = exp_q.pop_front();
    check("b_count", {16'h0, b_count}, {16'h0, e.cnt});
    check("b_wrap", {31'h0, b_wrap}, {31'h0, e.wrap});
    check("b_load_err", {31'h0, b_err}, {31'h0, e.err});
    check("b_hex", {4'h0, b_hex3, b_hex2, b_hex1, b_hex0}, {4'h0, e.hex});
  endtask

  task automatic cycle(input logic t, input logic e, input logic u, input logic l,
                       input logic [15:0] lv, input logic r);
    @(negedge clk);
    tick_in  = t;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
    rst      = r;
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic pulse(input logic e, input logic u, input int hi, input int lo);
    for (int i = 0; i < hi; i++) cycle(1'b1, e, u, 1'b0, 16'h0000, 1'b0);
    for (int i = 0; i < lo; i++) cycle(1'b0, e, u, 1'b0, 16'h0000, 1'b0);
  endtask

  task automatic do_load(input logic [15:0] v);
    cycle(1'b0, 1'b1, 1'b1, 1'b1, v, 1'b0);
  endtask

  initial begin
    // Reset with random inputs
    for (int i = 0; i < 2; i++)
      cycle(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom), 1'b1);
    idle(2);

    // Edge detect: long high pulses count once each
    for (int i = 0; i < 3; i++) pulse(1'b1, 1'b1, 5, 3);
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1);
    pulse(1'b1, 1'b1, 5, 3);
    pulse(1'b0, 1'b1, 5, 3);
    pulse(1'b1, 1'b1, 5, 3);

    // Carry and up-wrap
    do_load(16'h0099); pulse(1'b1, 1'b1, 1, 2);
    do_load(16'h9999); pulse(1'b1, 1'b1, 1, 3);

    // Borrow and down-wrap
    do_load(16'h0100); pulse(1'b1, 1'b0, 1, 2);
    do_load(16'h0000); pulse(1'b1, 1'b0, 1, 2);
    do_load(16'h0059); pulse(1'b1, 1'b1, 1, 2);

    // Load validation and load/rise collision
    do_load(16'h12A4); idle(1);
    do_load(16'h0060); idle(1);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0042, 1'b0);
    pulse(1'b1, 1'b1, 2, 2);

    // Reset collides with load and rise
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 16'h0500, 1'b1);
    idle(2);
    pulse(1'b1, 1'b1, 1, 2);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic        l;
      logic [15:0] lv;
      l  = ($urandom_range(0, 9) == 0);
      lv = ($urandom_range(0, 1) == 0) ? 16'($urandom) : dec2bcd($urandom_range(0, 9999));
      if ($urandom_range(0, 3) == 0) lv = dec2bcd($urandom_range(0, 70));
      cycle(1'($urandom), ($urandom_range(0, 3) != 0), 1'($urandom), l, lv,
            ($urandom_range(0, 49) == 0));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
